// File: rtl/multicycle_control_fsm.sv
// Moore main controller for the multicycle RISC-V core: sequences ALU, memory port and result mux selects.
// Latency with mem_ready=1 throughout: lw 5, sw 4, R/I-type 4, beq 3, jal 4 cycles.
// Backpressure: mem_ready=0 stalls FETCH/MEMREAD/MEMWRITE; optional abort after MEM_WAIT_MAX waits. Macro: MAIN_FSM_ILLEGAL_TRAP_EN.
module multicycle_control_fsm #(
   parameter int MEM_WAIT_MAX = 0,
   parameter int WAIT_CNT_W   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic       mem_timeout,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      , S_TRAP   = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   // Count value on which the final permitted wait cycle lands (only meaningful when MEM_WAIT_MAX != 0).
   localparam int                    WAIT_LAST_I = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST   = WAIT_LAST_I[WAIT_CNT_W-1:0];
   localparam logic [WAIT_CNT_W-1:0] WAIT_SAT    = '1;

   state_t                state_q, state_d, dec_state;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  waiting, timeout, pc_update, branch;

   assign waiting     = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
   // mem_ready in the final wait cycle takes priority over the abort.
   assign timeout     = (MEM_WAIT_MAX != 0) && waiting && !mem_ready && (wait_cnt_q == WAIT_LAST);
   assign mem_timeout = timeout && !reset;
   assign state_dbg   = state_q;

`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
   assign illegal_op = (state_q == S_TRAP) && !reset;
`else
   assign illegal_op = 1'b0;
`endif

   // State and wait-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state transitions, wait abort, and saturating count of consecutive not-ready cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
               default:      state_d = S_TRAP;
`else
               default:      state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_FETCH;
      endcase
      if (timeout) state_d = S_FETCH;

      wait_cnt_d = wait_cnt_q;
      if (timeout || (state_d != state_q))
         wait_cnt_d = '0;
      else if (waiting && !mem_ready && (wait_cnt_q != WAIT_SAT))
         wait_cnt_d = wait_cnt_q + 1'b1;
   end

   // Moore output decode; reset shows FETCH selects and kills every enable.
   always_comb begin
      dec_state = reset ? S_FETCH : state_q;
      PCWrite   = 1'b0;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ALUOp     = 2'b00;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (dec_state)
         S_FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            pc_update = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
         end
         S_ALUWB:    RegWrite = 1'b1;
         S_BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
         end
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
      PCWrite = pc_update | (branch & Zero);
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: a wait-forever instance and a MEM_WAIT_MAX=4 instance share stimulus.
// Directed vector table, hand sequences for timeout/reset corners, then random stimulus against a reference model.
// Define MAIN_FSM_ILLEGAL_TRAP_EN consistently for bench and RTL to exercise the trap build.
module tb_multicycle_control_fsm;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
   localparam int CNT_SAT = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [6:0] op = 7'd0;

   logic       pcw_a, adr_a, memw_a, irw_a, regw_a, tmo_a, ill_a;
   logic [1:0] res_a, sa_a, sb_a, alu_a;
   logic [3:0] st_a;
   logic       pcw_b, adr_b, memw_b, irw_b, regw_b, tmo_b, ill_b;
   logic [1:0] res_b, sa_b, sb_b, alu_b;
   logic [3:0] st_b;
   logic [18:0] got_a, got_b;

   int n_tests = 0;
   int n_fail  = 0;
   int ms0, mc0, ms4, mc4;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.MEM_WAIT_MAX(0), .WAIT_CNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(memw_a), .IRWrite(irw_a), .RegWrite(regw_a),
      .ResultSrc(res_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(alu_a),
      .mem_timeout(tmo_a), .illegal_op(ill_a), .state_dbg(st_a));

   multicycle_control_fsm #(.MEM_WAIT_MAX(4), .WAIT_CNT_W(8)) dut4 (
      .clk(clk), .reset(reset), .op(op), .Zero(Zero), .mem_ready(mem_ready),
      .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(memw_b), .IRWrite(irw_b), .RegWrite(regw_b),
      .ResultSrc(res_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(alu_b),
      .mem_timeout(tmo_b), .illegal_op(ill_b), .state_dbg(st_b));

   assign got_a = {st_a, pcw_a, adr_a, memw_a, irw_a, regw_a, res_a, sa_a, sb_a, alu_a, tmo_a, ill_a};
   assign got_b = {st_b, pcw_b, adr_b, memw_b, irw_b, regw_b, res_b, sa_b, sb_b, alu_b, tmo_b, ill_b};

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic       z;
      logic       mr;
      logic [3:0] st;
      logic       pcw, irw, regw, memw;
      logic [1:0] res, alu;
      logic       ill;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit is_wait(input int st);
      return (st == 0) || (st == 3) || (st == 5);
   endfunction

   function automatic bit model_tmo(input int st, input int cnt, input int mx, input logic rst, input logic mr);
      return !rst && (mx != 0) && is_wait(st) && !mr && (cnt == mx - 1);
   endfunction

   // Expected outputs from the per-state output table.
   function automatic logic [18:0] model_out(input int st, input int cnt, input int mx,
                                             input logic rst, input logic z, input logic mr);
      logic pcw, adr, memw, irw, regw, ill;
      logic [1:0] res, a, b, alu;
      logic [3:0] s4;
      int sel;
      s4 = st[3:0];
      sel = rst ? 0 : st;
      {pcw, adr, memw, irw, regw, ill} = '0;
      {res, a, b, alu} = '0;
      case (sel)
         0:  begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
         1:  begin a = 2'b01; b = 2'b01; end
         2:  begin a = 2'b10; b = 2'b01; end
         3:  adr = 1'b1;
         4:  begin res = 2'b01; regw = 1'b1; end
         5:  begin adr = 1'b1; memw = 1'b1; end
         6:  begin a = 2'b10; alu = 2'b10; end
         7:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
         8:  regw = 1'b1;
         9:  begin a = 2'b10; alu = 2'b01; pcw = z; end
         10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
         11: ill = 1'b1;
         default: ;
      endcase
      if (rst) {pcw, irw, regw, memw, ill} = '0;
      return {s4, pcw, adr, memw, irw, regw, res, a, b, alu, model_tmo(st, cnt, mx, rst, mr), ill};
   endfunction

   function automatic int decode_target(input logic [6:0] o);
      if (o == LW || o == SW) return 2;
      if (o == RT) return 6;
      if (o == IT) return 7;
      if (o == BQ) return 9;
      if (o == JL) return 10;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      return 11;
`else
      return 0;
`endif
   endfunction

   task automatic model_next(input int st, input int cnt, input int mx, input logic rst, input logic [6:0] o,
                             input logic mr, output int nst, output int ncnt);
      if (rst || model_tmo(st, cnt, mx, rst, mr)) begin
         nst = 0; ncnt = 0;
         return;
      end
      case (st)
         0:  nst = mr ? 1 : 0;
         1:  nst = decode_target(o);
         2:  nst = (o == LW) ? 3 : 5;
         3:  nst = mr ? 4 : 3;
         5:  nst = mr ? 0 : 5;
         6, 7, 10: nst = 8;
         11: nst = 11;
         default: nst = 0;
      endcase
      if (nst != st) ncnt = 0;
      else if (is_wait(st) && !mr) ncnt = (cnt < CNT_SAT) ? cnt + 1 : cnt;
      else ncnt = cnt;
   endtask

   // Drive inputs and compare both instances against the model before the next edge.
   task automatic apply(input logic r, input logic [6:0] o, input logic z, input logic mr);
      reset = r; op = o; Zero = z; mem_ready = mr;
      @(negedge clk);
      chk("model_max0", {13'd0, got_a}, {13'd0, model_out(ms0, mc0, 0, r, z, mr)});
      chk("model_max4", {13'd0, got_b}, {13'd0, model_out(ms4, mc4, 4, r, z, mr)});
   endtask

   task automatic advance();
      int n0, c0, n4, c4;
      model_next(ms0, mc0, 0, reset, op, mem_ready, n0, c0);
      model_next(ms4, mc4, 4, reset, op, mem_ready, n4, c4);
      ms0 = n0; mc0 = c0; ms4 = n4; mc4 = c4;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply(1'b1, 7'd0, 1'b0, 1'b1);
      advance();
   endtask

   task automatic addv(input logic rst, input logic [6:0] o, input logic z, input logic mr, input logic [3:0] st,
                       input logic pcw, input logic irw, input logic regw, input logic memw,
                       input logic [1:0] res, input logic [1:0] alu, input logic ill);
      vec_t v;
      v.rst = rst; v.op = o; v.z = z; v.mr = mr; v.st = st;
      v.pcw = pcw; v.irw = irw; v.regw = regw; v.memw = memw; v.res = res; v.alu = alu; v.ill = ill;
      tbl.push_back(v);
   endtask

   task automatic lw_to_memread();
      apply(0, LW, 0, 1); advance();
      apply(0, LW, 0, 1); advance();
      apply(0, LW, 0, 1); advance();
   endtask

   initial begin
      logic [6:0] rop;
      // reset row, then lw
      addv(1, LW, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
      addv(0, LW, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, LW, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, LW, 0, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, LW, 0, 1, 3, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, LW, 0, 1, 4, 0, 0, 1, 0, 2'b01, 2'b00, 0);
      // sw with three not-ready cycles in MEMWRITE
      addv(0, SW, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, SW, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, SW, 0, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      for (int i = 0; i < 3; i++) addv(0, SW, 0, 0, 5, 0, 0, 0, 1, 2'b00, 2'b00, 0);
      addv(0, SW, 0, 1, 5, 0, 0, 0, 1, 2'b00, 2'b00, 0);
      // beq taken, then not taken
      addv(0, BQ, 1, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, BQ, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, BQ, 1, 1, 9, 1, 0, 0, 0, 2'b00, 2'b01, 0);
      addv(0, BQ, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, BQ, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, BQ, 0, 1, 9, 0, 0, 0, 0, 2'b00, 2'b01, 0);
      // R-type, then jal
      addv(0, RT, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, RT, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, RT, 0, 1, 6, 0, 0, 0, 0, 2'b00, 2'b10, 0);
      addv(0, RT, 0, 1, 8, 0, 0, 1, 0, 2'b00, 2'b00, 0);
      addv(0, JL, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, JL, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, JL, 0, 1, 10, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, JL, 0, 1, 8, 0, 0, 1, 0, 2'b00, 2'b00, 0);
      // unlisted opcode
      addv(0, 7'd0, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, 7'd0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      addv(0, 7'd0, 0, 1, 11, 0, 0, 0, 0, 2'b00, 2'b00, 1);
      addv(1, 7'd0, 0, 1, 11, 0, 0, 0, 0, 2'b10, 2'b00, 0);
`else
      addv(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
      addv(1, 7'd0, 0, 1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);
`endif
      // reset during a pending store
      addv(0, SW, 0, 1, 0, 1, 1, 0, 0, 2'b10, 2'b00, 0);
      addv(0, SW, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, SW, 0, 1, 2, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      addv(0, SW, 0, 0, 5, 0, 0, 0, 1, 2'b00, 2'b00, 0);
      addv(1, SW, 0, 0, 5, 0, 0, 0, 0, 2'b10, 2'b00, 0);
      addv(0, SW, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0);

      // power-up reset
      reset = 1'b1;
      @(posedge clk);
      #1;
      ms0 = 0; mc0 = 0; ms4 = 0; mc4 = 0;

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].op, tbl[i].z, tbl[i].mr);
         chk($sformatf("vec%0d", i),
             {19'd0, st_a, pcw_a, irw_a, regw_a, memw_a, res_a, alu_a, ill_a},
             {19'd0, tbl[i].st, tbl[i].pcw, tbl[i].irw, tbl[i].regw, tbl[i].memw, tbl[i].res, tbl[i].alu, tbl[i].ill});
         advance();
      end

      // MEMREAD abort on the 4th not-ready cycle
      do_reset();
      lw_to_memread();
      for (int i = 0; i < 3; i++) begin
         apply(0, LW, 0, 0);
         chk("rd_wait_no_tmo", {31'd0, tmo_b}, 32'd0);
         advance();
      end
      apply(0, LW, 0, 0);
      chk("rd_tmo_pulse", {31'd0, tmo_b}, 32'd1);
      chk("rd_tmo_no_regwrite", {31'd0, regw_b}, 32'd0);
      advance();
      apply(0, LW, 0, 0);
      chk("rd_tmo_to_fetch", {28'd0, st_b}, 32'd0);
      chk("rd_tmo_one_cycle", {31'd0, tmo_b}, 32'd0);
      chk("max0_still_waits", {28'd0, st_a}, 32'd3);
      advance();

      // ready on the would-be abort cycle wins
      do_reset();
      lw_to_memread();
      for (int i = 0; i < 3; i++) begin apply(0, LW, 0, 0); advance(); end
      apply(0, LW, 0, 1);
      chk("rd_ready_wins_no_tmo", {31'd0, tmo_b}, 32'd0);
      advance();
      apply(0, LW, 0, 1);
      chk("rd_ready_wins_memwb", {28'd0, st_b}, 32'd4);
      chk("rd_ready_wins_regwrite", {31'd0, regw_b}, 32'd1);
      advance();

      // MEMWRITE abort keeps the strobe through the abort cycle
      do_reset();
      apply(0, SW, 0, 1); advance();
      apply(0, SW, 0, 1); advance();
      apply(0, SW, 0, 1); advance();
      for (int i = 0; i < 3; i++) begin apply(0, SW, 0, 0); advance(); end
      apply(0, SW, 0, 0);
      chk("wr_tmo_pulse", {31'd0, tmo_b}, 32'd1);
      chk("wr_tmo_memwrite_held", {31'd0, memw_b}, 32'd1);
      advance();
      apply(0, SW, 0, 0);
      chk("wr_tmo_memwrite_drop", {31'd0, memw_b}, 32'd0);
      chk("wr_tmo_to_fetch", {28'd0, st_b}, 32'd0);
      advance();

      // FETCH abort repeats every 4 not-ready cycles
      do_reset();
      for (int i = 0; i < 8; i++) begin
         apply(0, LW, 0, 0);
         chk($sformatf("fetch_tmo_c%0d", i), {31'd0, tmo_b}, {31'd0, (i % 4) == 3});
         chk($sformatf("fetch_tmo_irw_c%0d", i), {31'd0, irw_b}, 32'd0);
         advance();
      end

      // random stimulus against the model
      do_reset();
      rop = LW;
      for (int i = 0; i < 3000; i++) begin
         if (ms0 == 0 && ms4 == 0) begin
            case ($urandom_range(0, 6))
               0: rop = LW;
               1: rop = SW;
               2: rop = RT;
               3: rop = IT;
               4: rop = BQ;
               5: rop = JL;
               default: rop = 7'($urandom);
            endcase
         end
         apply(($urandom_range(0, 49) == 0), rop, 1'($urandom), ($urandom_range(0, 9) < 7));
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
